// File: rtl/vector_register_file.sv
// Vector register file: NUM_REGS x DATA_WIDTH, one combinational read port, one synchronous write.
// Optional same-cycle write-to-read forwarding when VRF_WRITE_BYPASS_EN is defined.
module vector_register_file #(
  parameter int unsigned NUM_REGS   = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] first_source_register,
  input  logic [ADDR_WIDTH-1:0] destination_register,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] stored_rd;
  logic                  src_valid;

  // Out-of-range destinations match no entry, so they write nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WE) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (destination_register == ADDR_WIDTH'(i)) begin
          regs_q[i] <= WD;
        end
      end
    end
  end

  always_comb begin
    stored_rd = '0;
    src_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (first_source_register == ADDR_WIDTH'(i)) begin
        stored_rd = regs_q[i];
        src_valid = 1'b1;
      end
    end
  end

`ifdef VRF_WRITE_BYPASS_EN
  always_comb begin
    RD = stored_rd;
    if (!rst && WE && src_valid && (first_source_register == destination_register)) begin
      RD = WD;
    end
  end
`else
  logic unused_src_valid;
  assign unused_src_valid = src_valid;
  assign RD = stored_rd;
`endif

endmodule

// File: tb/tb_vector_register_file.sv
// Self-checking bench for vector_register_file: directed table, reset corner cases,
// then randomized traffic checked against an array model.
module tb_vector_register_file;
  localparam int NR = 2;
  localparam int DW = 64;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [DW-1:0] wd  = '0;
  logic [DW-1:0] rd;

  always #5 clk = ~clk;

  vector_register_file #(
    .NUM_REGS  (NR),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .WE                   (we),
    .first_source_register(src),
    .destination_register (dst),
    .WD                   (wd),
    .RD                   (rd)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [NR];

  typedef struct {
    logic          we;
    logic [AW-1:0] dst;
    logic [DW-1:0] wd;
    logic [AW-1:0] src;
    logic [DW-1:0] exp_before;
    logic [DW-1:0] exp_after;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: RD=%h expected %h", name, act, exp);
    end
  endtask

  // What a reader should see given the stored contents and the current write request.
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] s, input logic w,
                                             input logic [AW-1:0] d, input logic [DW-1:0] data);
    logic [DW-1:0] r;
    r = (int'(s) < NR) ? model[s] : '0;
`ifdef VRF_WRITE_BYPASS_EN
    if (w && s == d && int'(s) < NR) r = data;
`endif
    return r;
  endfunction

  task automatic cycle(input logic w, input logic [AW-1:0] d, input logic [AW-1:0] s,
                       input logic [DW-1:0] data, input string name,
                       input logic [DW-1:0] eb, input logic [DW-1:0] ea);
    @(negedge clk);
    we = w; dst = d; src = s; wd = data;
    #1 check({name, "_pre"}, rd, eb);
    @(posedge clk);
    #1 check({name, "_post"}, rd, ea);
  endtask

  initial begin
    logic [DW-1:0] eb;
    logic          w;
    logic [AW-1:0] d, s;
    logic [DW-1:0] data;

    vecs[0] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 64'h1, 1'b0, 64'h0, 64'h0};
    vecs[3] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h1, 64'h1};
    vecs[4] = '{1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'h1, 64'hDEAD_BEEF_0000_0001};
    vecs[5] = '{1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1, 64'hDEAD_BEEF_0000_0001,
                64'hDEAD_BEEF_0000_0001};
    vecs[6] = '{1'b1, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5,
                64'hA5A5_A5A5_A5A5_A5A5};
    vecs[7] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 64'h5A5A_5A5A_5A5A_5A5A};
    vecs[8] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5};

    // Async reset pulse in the middle of the first low phase.
    #2 rst = 1'b1;
    #1 check("reset_async_r0", rd, '0);
    src = 1'b1;
    #1 check("reset_async_r1", rd, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    for (int i = 0; i < 9; i++) begin
      eb = vecs[i].exp_before;
`ifdef VRF_WRITE_BYPASS_EN
      if (vecs[i].we && vecs[i].src == vecs[i].dst) eb = vecs[i].wd;
`endif
      cycle(vecs[i].we, vecs[i].dst, vecs[i].src, vecs[i].wd, $sformatf("vec%0d", i), eb,
            vecs[i].exp_after);
      if (vecs[i].we) model[vecs[i].dst] = vecs[i].wd;
    end

    // Reset across an edge while a write to reg0 is pending.
    @(negedge clk);
    we = 1'b1; dst = 1'b0; src = 1'b0; wd = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("rstmid_pre", rd, model_rd(src, we, dst, wd));
    #1 rst = 1'b1;
    #1 check("rstmid_r0", rd, '0);
    src = 1'b1;
    #1 check("rstmid_r1", rd, '0);
    @(posedge clk);
    #1 check("rstmid_edge_r1", rd, '0);
    src = 1'b0;
    #1 check("rstmid_edge_r0", rd, '0);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #1 check("rstmid_release_r0", rd, '0);
    cycle(1'b1, 1'b0, 1'b1, 64'h2, "post_rst_wr", 64'h0, 64'h0);
    model[0] = 64'h2;
    cycle(1'b0, 1'b0, 1'b0, 64'h0, "post_rst_rd0", 64'h2, 64'h2);

    // Randomized traffic with occasional asynchronous resets.
    for (int it = 0; it < 300; it++) begin
      w    = 1'($urandom_range(0, 1));
      d    = AW'($urandom_range(0, NR - 1));
      s    = AW'($urandom_range(0, NR - 1));
      data = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        we = w; dst = d; src = s; wd = data;
        #2 rst = 1'b1;
        #1 check($sformatf("rnd%0d_rst", it), rd, '0);
        @(posedge clk);
        #1 check($sformatf("rnd%0d_rst_edge", it), rd, '0);
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
      end else begin
        eb = model_rd(s, w, d, data);
        @(negedge clk);
        we = w; dst = d; src = s; wd = data;
        #1 check($sformatf("rnd%0d_pre", it), rd, eb);
        if (w && int'(d) < NR) model[d] = data;
        @(posedge clk);
        #1 check($sformatf("rnd%0d_post", it), rd, model_rd(s, w, d, data));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
